// File: rtl/id2exe_pipe_reg.sv
// -----------------------------------------------------------------------------
// id2exe_pipe_reg
//
// Pipeline register between the ID and EXE stages. Captures the decoded
// instruction (controller signals, register numbers, operand values and PC+4)
// on every rising clock edge. The result is visible to EXE one cycle later.
//
// Stage control (single point of truth for the stall/kill handshake):
//   freeze=1, flush=0 : downstream stall. Every output holds its value.
//   flush=1           : taken branch. This edge captures a bubble, meaning all
//                       fields are zero and valid_out=0. flush beats freeze.
//   neither           : normal capture, one cycle of latency.
//   rst=0             : asynchronous clear of every output. This has priority
//                       over flush and freeze.
//
// Ports
//   clk, rst                       clock; asynchronous active-low reset
//   freeze, flush                  stage control, described above
//   PC_in .. reg2_in               ID-stage instruction fields
//   PC_out .. reg2_out             registered copies of those fields
//   valid_out                      1 = EXE holds a real instruction
//   bubble_cnt                     saturating count of bubble captures
//                                  (only when BUBBLE_CNT_EN is defined)
//
// Configuration macro: BUBBLE_CNT_EN adds the bubble_cnt port and its counter.
// -----------------------------------------------------------------------------
module id2exe_pipe_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        flush,
    input  logic [31:0] PC_in,
    input  logic        WB_EN_in,
    input  logic        MEM_R_EN_in,
    input  logic        MEM_W_EN_in,
    input  logic        Is_Imm_in,
    input  logic        ST_or_BNE_in,
    input  logic [3:0]  EXE_CMD_in,
    input  logic [4:0]  dest_in,
    input  logic [4:0]  src1_in,
    input  logic [4:0]  src2_in,
    input  logic [31:0] val1_in,
    input  logic [31:0] val2_in,
    input  logic [31:0] reg2_in,
    output logic [31:0] PC_out,
    output logic        WB_EN_out,
    output logic        MEM_R_EN_out,
    output logic        MEM_W_EN_out,
    output logic        Is_Imm_out,
    output logic        ST_or_BNE_out,
    output logic [3:0]  EXE_CMD_out,
    output logic [4:0]  dest_out,
    output logic [4:0]  src1_out,
    output logic [4:0]  src2_out,
    output logic [31:0] val1_out,
    output logic [31:0] val2_out,
    output logic [31:0] reg2_out,
    output logic        valid_out
`ifdef BUBBLE_CNT_EN
    ,
    output logic [15:0] bubble_cnt
`endif
);

    logic [31:0] pc_d,        pc_q;
    logic        wb_en_d,     wb_en_q;
    logic        mem_r_en_d,  mem_r_en_q;
    logic        mem_w_en_d,  mem_w_en_q;
    logic        is_imm_d,    is_imm_q;
    logic        st_or_bne_d, st_or_bne_q;
    logic [3:0]  exe_cmd_d,   exe_cmd_q;
    logic [4:0]  dest_d,      dest_q;
    logic [4:0]  src1_d,      src1_q;
    logic [4:0]  src2_d,      src2_q;
    logic [31:0] val1_d,      val1_q;
    logic [31:0] val2_d,      val2_q;
    logic [31:0] reg2_d,      reg2_q;
    logic        valid_d,     valid_q;

    // The controller drives all-zero control on a hazard. Such a capture is a
    // bubble even though its datapath fields are still taken. The raw
    // WB_EN_in is used here, so a write to r0 still counts as an instruction.
    logic ctrl_any;
    assign ctrl_any = WB_EN_in | MEM_R_EN_in | MEM_W_EN_in | (|EXE_CMD_in);

    // A capture edge is one that loads a new value (bubble or real) rather
    // than holding the current contents.
    logic capture;
    assign capture = flush | ~freeze;

    always_comb begin
        pc_d        = pc_q;
        wb_en_d     = wb_en_q;
        mem_r_en_d  = mem_r_en_q;
        mem_w_en_d  = mem_w_en_q;
        is_imm_d    = is_imm_q;
        st_or_bne_d = st_or_bne_q;
        exe_cmd_d   = exe_cmd_q;
        dest_d      = dest_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        val1_d      = val1_q;
        val2_d      = val2_q;
        reg2_d      = reg2_q;
        valid_d     = valid_q;
        if (flush) begin
            pc_d        = '0;
            wb_en_d     = 1'b0;
            mem_r_en_d  = 1'b0;
            mem_w_en_d  = 1'b0;
            is_imm_d    = 1'b0;
            st_or_bne_d = 1'b0;
            exe_cmd_d   = '0;
            dest_d      = '0;
            src1_d      = '0;
            src2_d      = '0;
            val1_d      = '0;
            val2_d      = '0;
            reg2_d      = '0;
            valid_d     = 1'b0;
        end else if (!freeze) begin
            pc_d        = PC_in;
            // Masking writes to r0 stops EXE/MEM from forwarding a bogus
            // value for register 0.
            wb_en_d     = WB_EN_in & (dest_in != 5'd0);
            mem_r_en_d  = MEM_R_EN_in;
            mem_w_en_d  = MEM_W_EN_in;
            is_imm_d    = Is_Imm_in;
            st_or_bne_d = ST_or_BNE_in;
            exe_cmd_d   = EXE_CMD_in;
            dest_d      = dest_in;
            src1_d      = src1_in;
            src2_d      = src2_in;
            val1_d      = val1_in;
            val2_d      = val2_in;
            reg2_d      = reg2_in;
            valid_d     = ctrl_any;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= '0;
            wb_en_q     <= 1'b0;
            mem_r_en_q  <= 1'b0;
            mem_w_en_q  <= 1'b0;
            is_imm_q    <= 1'b0;
            st_or_bne_q <= 1'b0;
            exe_cmd_q   <= '0;
            dest_q      <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            val1_q      <= '0;
            val2_q      <= '0;
            reg2_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            wb_en_q     <= wb_en_d;
            mem_r_en_q  <= mem_r_en_d;
            mem_w_en_q  <= mem_w_en_d;
            is_imm_q    <= is_imm_d;
            st_or_bne_q <= st_or_bne_d;
            exe_cmd_q   <= exe_cmd_d;
            dest_q      <= dest_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            val1_q      <= val1_d;
            val2_q      <= val2_d;
            reg2_q      <= reg2_d;
            valid_q     <= valid_d;
        end
    end

    assign PC_out        = pc_q;
    assign WB_EN_out     = wb_en_q;
    assign MEM_R_EN_out  = mem_r_en_q;
    assign MEM_W_EN_out  = mem_w_en_q;
    assign Is_Imm_out    = is_imm_q;
    assign ST_or_BNE_out = st_or_bne_q;
    assign EXE_CMD_out   = exe_cmd_q;
    assign dest_out      = dest_q;
    assign src1_out      = src1_q;
    assign src2_out      = src2_q;
    assign val1_out      = val1_q;
    assign val2_out      = val2_q;
    assign reg2_out      = reg2_q;
    assign valid_out     = valid_q;

`ifdef BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_d, bubble_cnt_q;

    // Count only edges that capture a bubble. Freeze-hold edges are not
    // counted. The counter saturates so that a long flush storm reads as
    // "at least 65535" and never wraps back to a small value.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (capture && !valid_d && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id2exe_pipe_reg.sv
module tb_id2exe_pipe_reg;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic [31:0] PC_in;
    logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, Is_Imm_in, ST_or_BNE_in;
    logic [3:0]  EXE_CMD_in;
    logic [4:0]  dest_in, src1_in, src2_in;
    logic [31:0] val1_in, val2_in, reg2_in;
    logic [31:0] PC_out;
    logic        WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, Is_Imm_out, ST_or_BNE_out;
    logic [3:0]  EXE_CMD_out;
    logic [4:0]  dest_out, src1_out, src2_out;
    logic [31:0] val1_out, val2_out, reg2_out;
    logic        valid_out;
`ifdef BUBBLE_CNT_EN
    logic [15:0] bubble_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    id2exe_pipe_reg dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .PC_in(PC_in), .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in),
        .MEM_W_EN_in(MEM_W_EN_in), .Is_Imm_in(Is_Imm_in), .ST_or_BNE_in(ST_or_BNE_in),
        .EXE_CMD_in(EXE_CMD_in), .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
        .val1_in(val1_in), .val2_in(val2_in), .reg2_in(reg2_in),
        .PC_out(PC_out), .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out),
        .MEM_W_EN_out(MEM_W_EN_out), .Is_Imm_out(Is_Imm_out), .ST_or_BNE_out(ST_or_BNE_out),
        .EXE_CMD_out(EXE_CMD_out), .dest_out(dest_out), .src1_out(src1_out),
        .src2_out(src2_out), .val1_out(val1_out), .val2_out(val2_out),
        .reg2_out(reg2_out), .valid_out(valid_out)
`ifdef BUBBLE_CNT_EN
        , .bubble_cnt(bubble_cnt)
`endif
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // The expected contents of the EXE stage, derived from the stage rules:
    // reset empties it, a flush puts a bubble in, a freeze leaves it alone,
    // and otherwise it takes the ID instruction.
    logic [31:0] m_pc, m_v1, m_v2, m_r2;
    logic        m_wb, m_mr, m_mw, m_imm, m_sb, m_valid;
    logic [3:0]  m_cmd;
    logic [4:0]  m_dest, m_s1, m_s2;
    int          m_bub;

    task automatic model_empty();
        {m_pc, m_v1, m_v2, m_r2} = '0;
        {m_wb, m_mr, m_mw, m_imm, m_sb, m_valid} = '0;
        m_cmd = '0; m_dest = '0; m_s1 = '0; m_s2 = '0;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_empty();
            m_bub = 0;
        end else if (flush) begin
            model_empty();
            if (m_bub < 65535) m_bub = m_bub + 1;
        end else if (!freeze) begin
            m_pc = PC_in; m_v1 = val1_in; m_v2 = val2_in; m_r2 = reg2_in;
            m_mr = MEM_R_EN_in; m_mw = MEM_W_EN_in; m_imm = Is_Imm_in; m_sb = ST_or_BNE_in;
            m_cmd = EXE_CMD_in; m_dest = dest_in; m_s1 = src1_in; m_s2 = src2_in;
            m_wb = WB_EN_in && (dest_in != 5'd0);
            m_valid = WB_EN_in || MEM_R_EN_in || MEM_W_EN_in || (EXE_CMD_in != 4'd0);
            if (!m_valid && m_bub < 65535) m_bub = m_bub + 1;
        end
    end

    // ---------------- scoreboard compare (every negedge) ----------------
    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_pc",    PC_out,        m_pc);
            chk("m_wb",    {31'd0, WB_EN_out},     {31'd0, m_wb});
            chk("m_mr",    {31'd0, MEM_R_EN_out},  {31'd0, m_mr});
            chk("m_mw",    {31'd0, MEM_W_EN_out},  {31'd0, m_mw});
            chk("m_imm",   {31'd0, Is_Imm_out},    {31'd0, m_imm});
            chk("m_sb",    {31'd0, ST_or_BNE_out}, {31'd0, m_sb});
            chk("m_cmd",   {28'd0, EXE_CMD_out},   {28'd0, m_cmd});
            chk("m_dest",  {27'd0, dest_out},      {27'd0, m_dest});
            chk("m_src1",  {27'd0, src1_out},      {27'd0, m_s1});
            chk("m_src2",  {27'd0, src2_out},      {27'd0, m_s2});
            chk("m_val1",  val1_out,      m_v1);
            chk("m_val2",  val2_out,      m_v2);
            chk("m_reg2",  reg2_out,      m_r2);
            chk("m_valid", {31'd0, valid_out},     {31'd0, m_valid});
`ifdef BUBBLE_CNT_EN
            chk("m_bubble_cnt", {16'd0, bubble_cnt}, m_bub[31:0]);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_ins();
        freeze = 0; flush = 0; PC_in = '0;
        WB_EN_in = 0; MEM_R_EN_in = 0; MEM_W_EN_in = 0; Is_Imm_in = 0; ST_or_BNE_in = 0;
        EXE_CMD_in = '0; dest_in = '0; src1_in = '0; src2_in = '0;
        val1_in = '0; val2_in = '0; reg2_in = '0;
    endtask

    task automatic ones_ins();
        PC_in = '1; WB_EN_in = 1; MEM_R_EN_in = 1; MEM_W_EN_in = 1; Is_Imm_in = 1;
        ST_or_BNE_in = 1; EXE_CMD_in = '1; dest_in = '1; src1_in = '1; src2_in = '1;
        val1_in = '1; val2_in = '1; reg2_in = '1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every output must be zero, as it is when the stage has just been reset.
    task automatic chk_all_zero(input string tag);
        chk({tag, "_pc"},    PC_out, 32'd0);
        chk({tag, "_ctrl"},  {27'd0, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out, Is_Imm_out, ST_or_BNE_out}, 32'd0);
        chk({tag, "_cmd"},   {28'd0, EXE_CMD_out}, 32'd0);
        chk({tag, "_regs"},  {17'd0, dest_out, src1_out, src2_out}, 32'd0);
        chk({tag, "_vals"},  val1_out | val2_out | reg2_out, 32'd0);
        chk({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
`ifdef BUBBLE_CNT_EN
        chk({tag, "_bcnt"},  {16'd0, bubble_cnt}, 32'd0);
`endif
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        wb, mw, fz, fl;
        logic [3:0]  cmd;
        logic [4:0]  dest;
        logic [31:0] v1;
    } vec_t;

    vec_t vecs[6];

    // ---------------- main sequence ----------------
    initial begin
        int bcnt_snap;
        clear_ins();
        ones_ins();
        rst = 1'b0;
        // Asynchronous reset with all inputs high and no clock edge yet.
        #1;
        chk_all_zero("reset_por");

        // Release reset away from an edge and load the pass-through vector.
        tick();
        rst = 1'b1;
        cmp_en = 1'b1;
        clear_ins();
        PC_in = 32'h10; EXE_CMD_in = 4'd1; WB_EN_in = 1; dest_in = 5'd3; val1_in = 32'h5;
        tick();
        chk("pass_pc",    PC_out, 32'h10);
        chk("pass_cmd",   {28'd0, EXE_CMD_out}, 32'd1);
        chk("pass_wb",    {31'd0, WB_EN_out}, 32'd1);
        chk("pass_dest",  {27'd0, dest_out}, 32'd3);
        chk("pass_val1",  val1_out, 32'h5);
        chk("pass_valid", {31'd0, valid_out}, 32'd1);

        // Freeze for three edges while new data waits at the inputs.
        freeze = 1; PC_in = 32'h20;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("freeze_pc",    PC_out, 32'h10);
            chk("freeze_valid", {31'd0, valid_out}, 32'd1);
`ifdef BUBBLE_CNT_EN
            chk("freeze_bcnt",  {16'd0, bubble_cnt}, 32'd0);
`endif
        end

        // Flush and freeze at the same time: the flush inserts a bubble.
        flush = 1; MEM_W_EN_in = 1;
        tick();
        chk("flfz_memw",  {31'd0, MEM_W_EN_out}, 32'd0);
        chk("flfz_cmd",   {28'd0, EXE_CMD_out}, 32'd0);
        chk("flfz_valid", {31'd0, valid_out}, 32'd0);
        chk("flfz_pc",    PC_out, 32'd0);
`ifdef BUBBLE_CNT_EN
        chk("flfz_bcnt",  {16'd0, bubble_cnt}, 32'd1);
`endif

        // A write to r0 is captured with its write-back enable cleared.
        clear_ins();
        dest_in = 5'd0; WB_EN_in = 1; EXE_CMD_in = 4'd1; PC_in = 32'h44;
        tick();
        chk("r0_wb",    {31'd0, WB_EN_out}, 32'd0);
        chk("r0_valid", {31'd0, valid_out}, 32'd1);
        chk("r0_cmd",   {28'd0, EXE_CMD_out}, 32'd1);

        // All-zero control from a hazard: a bubble, but the datapath is still taken.
        clear_ins();
        PC_in = 32'h88; val1_in = 32'hCAFE; val2_in = 32'hBEEF; reg2_in = 32'h1234;
        src1_in = 5'd7; Is_Imm_in = 1;
        tick();
        chk("hz_valid", {31'd0, valid_out}, 32'd0);
        chk("hz_pc",    PC_out, 32'h88);
        chk("hz_val1",  val1_out, 32'hCAFE);
        chk("hz_src1",  {27'd0, src1_out}, 32'd7);
`ifdef BUBBLE_CNT_EN
        chk("hz_bcnt",  {16'd0, bubble_cnt}, 32'd2);
`endif

        // A short table of mixed captures, freezes and flushes that only the model checks.
        vecs[0] = '{pc: 32'h100, wb: 1, mw: 0, fz: 0, fl: 0, cmd: 4'd2,  dest: 5'd9,  v1: 32'h11};
        vecs[1] = '{pc: 32'h104, wb: 0, mw: 1, fz: 1, fl: 0, cmd: 4'd8,  dest: 5'd0,  v1: 32'h22};
        vecs[2] = '{pc: 32'h108, wb: 0, mw: 1, fz: 0, fl: 0, cmd: 4'd0,  dest: 5'd4,  v1: 32'h33};
        vecs[3] = '{pc: 32'h10C, wb: 1, mw: 0, fz: 0, fl: 1, cmd: 4'd6,  dest: 5'd5,  v1: 32'h44};
        vecs[4] = '{pc: 32'h110, wb: 0, mw: 0, fz: 1, fl: 0, cmd: 4'd0,  dest: 5'd6,  v1: 32'h55};
        vecs[5] = '{pc: 32'h114, wb: 1, mw: 0, fz: 0, fl: 0, cmd: 4'd15, dest: 5'd31, v1: 32'hFFFF_FFFF};
        for (int i = 0; i < 6; i++) begin
            clear_ins();
            PC_in = vecs[i].pc; WB_EN_in = vecs[i].wb; MEM_W_EN_in = vecs[i].mw;
            freeze = vecs[i].fz; flush = vecs[i].fl; EXE_CMD_in = vecs[i].cmd;
            dest_in = vecs[i].dest; val1_in = vecs[i].v1;
            src2_in = 5'(i + 1); val2_in = 32'(i * 3); reg2_in = ~vecs[i].v1;
            tick();
        end
        chk("tbl_last_pc",   PC_out, 32'h114);
        chk("tbl_last_dest", {27'd0, dest_out}, 32'd31);

        // Reset in the middle of a cycle discards the held instruction at once.
        ones_ins();
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("reset_mid");
        tick();
        chk_all_zero("reset_held");
        rst = 1'b1;
        clear_ins();
        PC_in = 32'h200; MEM_R_EN_in = 1; dest_in = 5'd12; val2_in = 32'h77;
        tick();
        chk("post_rst_pc",    PC_out, 32'h200);
        chk("post_rst_memr",  {31'd0, MEM_R_EN_out}, 32'd1);
        chk("post_rst_valid", {31'd0, valid_out}, 32'd1);

`ifdef BUBBLE_CNT_EN
        // Saturation: 65537 flush edges after a reset must stop at FFFF.
        rst = 1'b0;
        #1;
        rst = 1'b1;
        clear_ins();
        flush = 1;
        for (int i = 0; i < 65537; i++) tick();
        chk("sat_bcnt", {16'd0, bubble_cnt}, 32'h0000_FFFF);
        flush = 0;
        tick();
        chk("sat_hold_bcnt", {16'd0, bubble_cnt}, 32'h0000_FFFF);
`endif

        clear_ins();
        tick();
        tick();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
